count_en_ctrl: RTL and testbench



---
 rtl/count_en_pkg.sv | 18 +
 rtl/btn_debounce.sv | 55 +++++
 rtl/count_en_ctrl.sv | 116 +++++++++++
 tb/tb_count_en_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_en_pkg.sv
// Shared types and widths for the counter clock-enable controller.
package count_en_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        STEP   = 2'd2
    } en_state_t;

    localparam int DIV_W  = 16;
    localparam int STEP_W = 16;

    // Width needed to hold values 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button to single-cycle press pulse: synchroniser, debounce, edge detect.
module btn_debounce
    import count_en_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int              CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles;
    // the pulse fires on the same edge the stable level rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 != stable) begin
                if (cnt == LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                    press  <= sync2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/count_en_ctrl.sv
// Clock-enable generator for the LED counter: run (divided), pause, and
// fixed-length single-step, with an external debug halt.
module count_en_ctrl
    import count_en_pkg::*;
#(
    parameter int DIV_RATIO       = 1,
    parameter int DEBOUNCE_CYCLES = 3000000,
    parameter int STEP_CYCLES     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_pause,
    input  logic        btn_step,
    input  logic        ext_halt,
    output logic        clk_en,
    output logic        paused,
    output logic        step_busy,
    output logic [15:0] step_cnt_total
);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_RATIO - 1);
    localparam logic [STEP_W-1:0] STEP_INIT = STEP_W'(STEP_CYCLES);

    en_state_t         state, state_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [STEP_W-1:0] step_left, step_left_nxt;
    logic [15:0]       step_total, step_total_nxt;
    logic              clk_en_nxt;
    logic              pause_p;
    logic              step_p;
    logic              tick;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_pause),
        .press (pause_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_step),
        .press (step_p)
    );

    assign tick           = (div_cnt == DIV_LAST);
    assign step_cnt_total = step_total;

    // Next state, divider, step budget and enable; halt freezes the counters
    // but presses are still honoured.
    always_comb begin
        state_nxt      = state;
        div_nxt        = div_cnt;
        step_left_nxt  = step_left;
        step_total_nxt = step_total;
        clk_en_nxt     = 1'b0;
        case (state)
            RUN: begin
                if (pause_p) begin
                    state_nxt = PAUSED;
                end else if (!ext_halt) begin
                    clk_en_nxt = tick;
                    div_nxt    = tick ? '0 : div_cnt + DIV_W'(1);
                end
            end
            PAUSED: begin
                // Pause wins over a coincident step press.
                if (pause_p) begin
                    state_nxt = RUN;
                    div_nxt   = '0;
                end else if (step_p) begin
                    state_nxt      = STEP;
                    step_left_nxt  = STEP_INIT;
                    step_total_nxt = step_total + 16'd1;
                end
            end
            STEP: begin
                // Presses are ignored here; the step burst always completes.
                if (!ext_halt) begin
                    clk_en_nxt    = 1'b1;
                    step_left_nxt = step_left - STEP_W'(1);
                    if (step_left == STEP_W'(1))
                        state_nxt = PAUSED;
                end
            end
            default: begin
                state_nxt = RUN;
                div_nxt   = '0;
            end
        endcase
    end

    // State, counters and registered outputs; status flags decode the
    // current state so they line up with the enable cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            div_cnt    <= '0;
            step_left  <= '0;
            step_total <= '0;
            clk_en     <= 1'b0;
            paused     <= 1'b0;
            step_busy  <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            step_left  <= step_left_nxt;
            step_total <= step_total_nxt;
            clk_en     <= clk_en_nxt;
            paused     <= (state != RUN);
            step_busy  <= (state == STEP);
        end
    end

endmodule

// File: tb/tb_count_en_ctrl.sv
// Self-checking bench: two controller instances (DIV 3/STEP 2 and DIV 1/STEP 5)
// share stimulus and are compared every cycle against a behavioural model.
module tb_count_en_ctrl;

    localparam int DEB = 4;
    localparam int M_RUN = 0, M_PAUSED = 1, M_STEP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_pause = 1'b0, btn_step = 1'b0, ext_halt = 1'b0;
    logic        en_a, paused_a, busy_a, en_b, paused_b, busy_b;
    logic [15:0] total_a, total_b;

    always #5 clk = ~clk;

    count_en_ctrl #(.DIV_RATIO(3), .DEBOUNCE_CYCLES(DEB), .STEP_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .btn_pause(btn_pause), .btn_step(btn_step),
        .ext_halt(ext_halt), .clk_en(en_a), .paused(paused_a),
        .step_busy(busy_a), .step_cnt_total(total_a)
    );

    count_en_ctrl #(.DIV_RATIO(1), .DEBOUNCE_CYCLES(DEB), .STEP_CYCLES(5)) dut_b (
        .clk(clk), .rst(rst), .btn_pause(btn_pause), .btn_step(btn_step),
        .ext_halt(ext_halt), .clk_en(en_b), .paused(paused_b),
        .step_busy(busy_b), .step_cnt_total(total_b)
    );

    int vectors = 0;
    int miscompares = 0;
    int cnt_en_a = 0, cnt_en_b = 0;

    // ---------------- behavioural model ----------------
    int m_mode[2], m_runc[2], m_left[2], m_total[2];
    bit m_en[2], m_pa[2], m_sb[2];
    bit hp[2], hs[2];               // raw samples from two and one edges ago
    bit stab_p, stab_s, pul_p, pul_s;
    int run_p, run_s;

    function automatic int div_of(input int k);  return (k == 0) ? 3 : 1; endfunction
    function automatic int step_of(input int k); return (k == 0) ? 2 : 5; endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_RUN; m_runc[k] = 0; m_left[k] = 0; m_total[k] = 0;
            m_en[k] = 0; m_pa[k] = 0; m_sb[k] = 0;
        end
        hp = '{0, 0}; hs = '{0, 0};
        stab_p = 0; stab_s = 0; pul_p = 0; pul_s = 0; run_p = 0; run_s = 0;
    endtask

    // A level is accepted once the synchronised input has disagreed with it
    // for DEB consecutive cycles.
    task automatic deb(input bit seen, inout bit stab, inout int run, output bit pulse);
        pulse = 0;
        if (seen != stab) begin
            run++;
            if (run == DEB) begin
                stab = seen; run = 0; pulse = seen;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_edge();
        bit np, ns;
        for (int k = 0; k < 2; k++) begin
            m_pa[k] = (m_mode[k] != M_RUN);
            m_sb[k] = (m_mode[k] == M_STEP);
            m_en[k] = 0;
            case (m_mode[k])
                M_RUN: begin
                    if (pul_p) m_mode[k] = M_PAUSED;
                    else if (!ext_halt) begin
                        m_runc[k]++;
                        m_en[k] = (m_runc[k] % div_of(k)) == 0;
                    end
                end
                M_PAUSED: begin
                    if (pul_p) begin
                        m_mode[k] = M_RUN; m_runc[k] = 0;
                    end else if (pul_s) begin
                        m_mode[k]  = M_STEP;
                        m_left[k]  = step_of(k);
                        m_total[k] = (m_total[k] + 1) % 65536;
                    end
                end
                default: begin
                    if (!ext_halt) begin
                        m_en[k] = 1;
                        m_left[k]--;
                        if (m_left[k] == 0) m_mode[k] = M_PAUSED;
                    end
                end
            endcase
        end
        deb(hp[0], stab_p, run_p, np);
        deb(hs[0], stab_s, run_s, ns);
        pul_p = np; pul_s = ns;
        hp[0] = hp[1]; hp[1] = btn_pause;
        hs[0] = hs[1]; hs[1] = btn_step;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("model clk_en a", int'(en_a), int'(m_en[0]));
        chk("model paused a", int'(paused_a), int'(m_pa[0]));
        chk("model step_busy a", int'(busy_a), int'(m_sb[0]));
        chk("model total a", int'(total_a), m_total[0]);
        chk("model clk_en b", int'(en_b), int'(m_en[1]));
        chk("model paused b", int'(paused_b), int'(m_pa[1]));
        chk("model step_busy b", int'(busy_b), int'(m_sb[1]));
        chk("model total b", int'(total_b), m_total[1]);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        @(negedge clk);
        if (en_a === 1'b1) cnt_en_a++;
        if (en_b === 1'b1) cnt_en_b++;
        cmp_all();
    endtask

    task automatic drive(input bit p, input bit s, input bit h, input int n);
        btn_pause = p; btn_step = s; ext_halt = h;
        for (int i = 0; i < n; i++) cyc();
    endtask

    typedef struct {
        bit p, s, h;
        int n;
        int en_a, en_b;
        int paused_a;
        int total_a;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int got;
        model_reset();
        tbl[0] = '{0, 0, 0, 12, 4, 12, 0, 0};  // divided run after reset
        tbl[1] = '{1, 0, 0,  3, 1,  3, 0, 0};  // 3-cycle glitch on pause
        tbl[2] = '{0, 0, 0, 10, 3, 10, 0, 0};  // glitch rejected, still running
        tbl[3] = '{1, 0, 0, 20, 2,  6, 1, 0};  // real press: paused on 7th edge
        tbl[4] = '{0, 0, 0, 10, 0,  0, 1, 0};  // release gives no pulse
        tbl[5] = '{0, 1, 0, 10, 2,  3, 1, 1};  // step burst
        tbl[6] = '{0, 0, 0, 10, 0,  2, 1, 1};
        tbl[7] = '{0, 1, 0, 10, 2,  3, 1, 2};  // second step
        tbl[8] = '{0, 0, 0, 10, 0,  2, 1, 2};
        tbl[9] = '{1, 0, 0, 10, 1,  3, 0, 2};  // back to run, divider restarted

        // reset state
        repeat (3) cyc();
        chk("reset clk_en a", int'(en_a), 0);
        chk("reset paused a", int'(paused_a), 0);
        chk("reset step_busy b", int'(busy_b), 0);
        chk("reset total a", int'(total_a), 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            cnt_en_a = 0; cnt_en_b = 0;
            drive(tbl[i].p, tbl[i].s, tbl[i].h, tbl[i].n);
            chk($sformatf("tbl[%0d] enables a", i), cnt_en_a, tbl[i].en_a);
            chk($sformatf("tbl[%0d] enables b", i), cnt_en_b, tbl[i].en_b);
            chk($sformatf("tbl[%0d] paused a", i), int'(paused_a), tbl[i].paused_a);
            chk($sformatf("tbl[%0d] total a", i), int'(total_a), tbl[i].total_a);
        end

        // halt in the middle of a 5-cycle step burst (instance b)
        drive(0, 0, 0, 10);
        drive(1, 0, 0, 10);
        drive(0, 0, 0, 10);
        btn_step = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            cyc();
            got = int'(en_b);
        end
        chk("halt seq first enable b", got, 1);
        cyc();
        chk("halt seq second enable b", int'(en_b), 1);
        ext_halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("halt seq clk_en low b", int'(en_b), 0);
        end
        ext_halt = 1'b0;
        cnt_en_b = 0;
        for (int i = 0; i < 6; i++) cyc();
        chk("halt seq remaining enables b", cnt_en_b, 3);
        chk("halt seq back to paused b", int'(busy_b), 0);
        chk("halt seq total b", int'(total_b), 3);

        // coincident pause and step presses in PAUSED: pause wins
        drive(0, 0, 0, 10);
        drive(1, 1, 0, 6);
        cyc(); chk("coincide edge7 clk_en a", int'(en_a), 0);
        cyc(); chk("coincide edge8 clk_en a", int'(en_a), 0);
        cyc(); chk("coincide edge9 clk_en a", int'(en_a), 0);
        cyc(); chk("coincide edge10 clk_en a", int'(en_a), 1);
        chk("coincide total a", int'(total_a), 3);
        chk("coincide paused a", int'(paused_a), 0);

        // asynchronous reset in the middle of a step burst
        drive(0, 0, 0, 10);
        drive(1, 0, 0, 10);
        drive(0, 0, 0, 10);
        btn_step = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            cyc();
            got = int'(busy_b);
        end
        chk("rst seq reached step b", got, 1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async rst clk_en b", int'(en_b), 0);
        chk("async rst paused b", int'(paused_b), 0);
        chk("async rst step_busy b", int'(busy_b), 0);
        btn_step = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cnt_en_a = 0; cnt_en_b = 0;
        drive(0, 0, 0, 9);
        chk("post rst enables a", cnt_en_a, 3);
        chk("post rst enables b", cnt_en_b, 9);
        chk("post rst total a", int'(total_a), 0);

        // step counter wrap
        drive(1, 0, 0, 10);
        drive(0, 0, 0, 10);
        force dut_a.step_total = 16'hFFFF;
        force dut_b.step_total = 16'hFFFF;
        #1;
        release dut_a.step_total;
        release dut_b.step_total;
        m_total[0] = 16'hFFFF; m_total[1] = 16'hFFFF;
        drive(0, 1, 0, 10);
        drive(0, 0, 0, 10);
        chk("wrap total a", int'(total_a), 0);
        chk("wrap total b", int'(total_b), 0);

        // random segments against the model
        for (int seg = 0; seg < 400; seg++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), $urandom_range(1, 12));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
